// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants and types for the PRESENT-80 round stage
package present_pkg;

  localparam int BLOCK_SIZE   = 64;
  localparam int KEY_SIZE     = 80;
  localparam int NUM_ROUNDS   = 31;
  localparam int ROUND_KEY_HI = 79;
  localparam int ROUND_KEY_LO = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    WAIT  = 2'd2,
    FINAL = 2'd3
  } rks_state_t;

endpackage

// File: rtl/present_key_schedule.sv
// rtl/present_key_schedule.sv - combinational PRESENT-80 key update for one round
module present_key_schedule
  import present_pkg::*;
(
  input  logic [KEY_SIZE-1:0] key,
  input  logic [4:0]          rc,
  output logic [KEY_SIZE-1:0] next_key
);

  logic [KEY_SIZE-1:0] rot;
  logic [3:0]          top_sub;

  // rotate left by 61 is the same as rotate right by 19
  assign rot = {key[18:0], key[79:19]};

  present_sbox u_sbox (
    .din  (rot[79:76]),
    .dout (top_sub)
  );

  // splice the substituted top nibble and the round counter into the rotated key
  always_comb begin
    next_key        = {top_sub, rot[75:0]};
    next_key[19:15] = rot[19:15] ^ rc;
  end

endmodule

// File: rtl/present_sbox.sv
// rtl/present_sbox.sv - 4-bit PRESENT substitution box
module present_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // fixed PRESENT nibble substitution
  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      4'hF: dout = 4'h2;
      default: dout = 4'h0;
    endcase
  end

endmodule

// File: rtl/round_key_stage.sv
// rtl/round_key_stage.sv - iterative PRESENT-80 round controller and add-round-key stage
module round_key_stage
  import present_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLOCK_SIZE-1:0] in_block,
  input  logic [KEY_SIZE-1:0]   in_key,
  output logic                  sub_valid,
  input  logic                  sub_ready,
  output logic [BLOCK_SIZE-1:0] sub_data,
  input  logic                  ret_valid,
  input  logic [BLOCK_SIZE-1:0] ret_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] out_data
);

  rks_state_t            fsm, fsm_d;
  logic [BLOCK_SIZE-1:0] state_q, state_d;
  logic [KEY_SIZE-1:0]   key_q, key_d, key_sched;
  logic [4:0]            round_q, round_d;
  logic [BLOCK_SIZE-1:0] rk_mix;
  logic [BLOCK_SIZE-1:0] sub_data_d, out_data_d;

  present_key_schedule u_key_schedule (
    .key      (key_q),
    .rc       (round_q),
    .next_key (key_sched)
  );

  // FSM, cipher state, key, round counter and the registered XOR outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm      <= IDLE;
      state_q  <= '0;
      key_q    <= '0;
      round_q  <= 5'd1;
      sub_data <= '0;
      out_data <= '0;
    end else begin
      fsm      <= fsm_d;
      state_q  <= state_d;
      key_q    <= key_d;
      round_q  <= round_d;
      sub_data <= sub_data_d;
      out_data <= out_data_d;
    end
  end

  // next state: each handshake advances the FSM and loads state/key/round
  always_comb begin
    fsm_d   = fsm;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    case (fsm)
      IDLE: begin
        if (in_valid) begin
          state_d = in_block;
          key_d   = in_key;
          round_d = 5'd1;
          fsm_d   = ADD;
        end
      end
      ADD: begin
        if (sub_ready) begin
          key_d = key_sched;
          fsm_d = WAIT;
        end
      end
      WAIT: begin
        if (ret_valid) begin
          state_d = ret_data;
          if (round_q == 5'(NUM_ROUNDS)) begin
            fsm_d = FINAL;
          end else begin
            round_d = round_q + 5'd1;
            fsm_d   = ADD;
          end
        end
      end
      FINAL: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // the XOR is taken on next-cycle state/key so the data registers line up with the valids
  assign rk_mix = state_d ^ key_d[ROUND_KEY_HI:ROUND_KEY_LO];

  // outputs: valids decode the current state, data is staged from the next state
  always_comb begin
    in_ready   = (fsm == IDLE);
    sub_valid  = (fsm == ADD);
    out_valid  = (fsm == FINAL);
    sub_data_d = (fsm_d == ADD)   ? rk_mix : '0;
    out_data_d = (fsm_d == FINAL) ? rk_mix : '0;
  end

endmodule

// File: tb/tb_round_key_stage.sv
// tb/tb_round_key_stage.sv - self-checking bench for round_key_stage with SubsLayer/P-layer loop
module tb_round_key_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, sub_valid, sub_ready;
  logic        ret_valid, out_valid, out_ready;
  logic [63:0] in_block, sub_data, ret_data, out_data;
  logic [79:0] in_key;

  always #5 clk = ~clk;

  round_key_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .sub_valid (sub_valid),
    .sub_ready (sub_ready),
    .sub_data  (sub_data),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference cipher pieces
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = sbox4(s[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] player(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[(i == 63) ? 63 : ((i * 16) % 63)] = s[i];
    return r;
  endfunction

  // state XOR round key at the start of round r; r = 32 gives the ciphertext
  function automatic logic [63:0] enc_upto(input logic [63:0] pt, input logic [79:0] key, input int r);
    logic [63:0] s;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int i = 1; i < r; i++) begin
      s = player(sbox_layer(s ^ k[79:16]));
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox4(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(i);
    end
    return s ^ k[79:16];
  endfunction

  // scoreboard state shared between the loop process and the directed sequence
  int          cyc = 0;
  logic        busy = 1'b0;
  logic [63:0] cur_pt = '0;
  logic [79:0] cur_key = '0;
  int          sub_idx = 1;
  logic        pending = 1'b0;
  logic [63:0] pend_data = '0;
  int          pend_round = 0;
  logic        out_seen = 1'b0;
  int          accept_cyc = 0;
  int          stalls = 0;
  int          lat_last = 0;
  int          accept_count = 0;
  int          out_hs_cyc = 0;
  logic        stall_mode = 1'b0;
  logic        hold_out = 1'b0;
  logic        force_ret = 1'b0;
  logic [63:0] results[$];

  // compare DUT outputs against the model every cycle, then play SubsLayer/P-layer and consumer
  always @(negedge clk) begin
    logic pend_now;
    cyc++;
    check_int("in_ready", int'(in_ready), int'(!busy));
    if (!busy) begin
      check_int("sub_valid_idle", int'(sub_valid), 0);
      check_int("out_valid_idle", int'(out_valid), 0);
    end
    if (sub_valid) check64("sub_data", sub_data, enc_upto(cur_pt, cur_key, sub_idx));
    else           check64("sub_data_zero", sub_data, 64'h0);
    if (out_valid) begin
      check64("out_data", out_data, enc_upto(cur_pt, cur_key, 32));
      if (!out_seen) begin
        out_seen = 1'b1;
        lat_last = cyc - accept_cyc;
        check_int("latency", lat_last, 63 + stalls);
      end
    end else begin
      check64("out_data_zero", out_data, 64'h0);
    end

    pend_now = pending;
    if (force_ret) begin
      ret_valid = 1'b1;
      ret_data  = 64'hDEADBEEFCAFEF00D;
      force_ret = 1'b0;
    end else if (pend_now) begin
      ret_valid = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      ret_data  = pend_data;
      if (ret_valid) pending = 1'b0;
      else           stalls++;
    end else begin
      ret_valid = stall_mode && ($urandom_range(0, 3) == 0);
      ret_data  = {$urandom, $urandom};
    end

    sub_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (sub_valid && sub_ready && !reset) begin
      pending    = 1'b1;
      pend_data  = player(sbox_layer(sub_data));
      pend_round = sub_idx;
      sub_idx++;
    end else if (sub_valid && !sub_ready) begin
      stalls++;
    end

    out_ready = hold_out ? 1'b0 : (stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
    if (out_valid && out_ready && !reset) begin
      results.push_back(out_data);
      busy       = 1'b0;
      out_hs_cyc = cyc;
    end

    if (in_valid && in_ready && !reset) begin
      busy       = 1'b1;
      cur_pt     = in_block;
      cur_key    = in_key;
      sub_idx    = 1;
      out_seen   = 1'b0;
      stalls     = 0;
      accept_cyc = cyc;
      accept_count++;
    end

    if (reset) begin
      busy    = 1'b0;
      pending = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [63:0] pt, input logic [79:0] k);
    int n0;
    int t;
    n0 = accept_count;
    t = 0;
    in_block = pt;
    in_key   = k;
    in_valid = 1'b1;
    while (accept_count == n0 && t < 500) begin
      step();
      t++;
    end
    check_int("accept_timeout", int'(accept_count != n0), 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (results.size() < target && t < 3000) begin
      step();
      t++;
    end
    check_int("done_timeout", int'(results.size() >= target), 1);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 3000) begin
      step();
      t++;
    end
    check_int("out_valid_timeout", int'(out_valid), 1);
  endtask

  function automatic logic [63:0] result_at(input int i);
    if (i < results.size()) return results[i];
    return 64'hX;
  endfunction

  initial begin
    int t;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    in_key    = '0;
    sub_ready = 1'b0;
    ret_valid = 1'b0;
    ret_data  = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_sub_valid", int'(sub_valid), 0);
    check_int("reset_out_valid", int'(out_valid), 0);
    check64("reset_sub_data", sub_data, 64'h0);
    check64("reset_out_data", out_data, 64'h0);

    check64("model_pt0_k0", enc_upto(64'h0, 80'h0, 32), 64'h5579C1387B228445);
    check64("model_pt0_k1", enc_upto(64'h0, {80{1'b1}}, 32), 64'hE72C46C0F5945049);
    check64("model_pt1_k0", enc_upto({64{1'b1}}, 80'h0, 32), 64'hA112FFC72F68417B);
    check64("model_pt1_k1", enc_upto({64{1'b1}}, {80{1'b1}}, 32), 64'h3333DCD3213210D2);

    // vector 1 with a fully ready loop
    send(64'h0, 80'h0);
    wait_done(1);
    check64("ct_v1", result_at(0), 64'h5579C1387B228445);
    check_int("latency_v1", lat_last, 63);

    // remaining reference vectors
    send(64'h0, {80{1'b1}});
    wait_done(2);
    check64("ct_v2", result_at(1), 64'hE72C46C0F5945049);
    send({64{1'b1}}, 80'h0);
    wait_done(3);
    check64("ct_v3", result_at(2), 64'hA112FFC72F68417B);
    send({64{1'b1}}, {80{1'b1}});
    wait_done(4);
    check64("ct_v4", result_at(3), 64'h3333DCD3213210D2);

    // random stalls on every handshake
    stall_mode = 1'b1;
    send(64'h0, 80'h0);
    wait_done(5);
    stall_mode = 1'b0;
    check64("ct_stall", result_at(4), 64'h5579C1387B228445);
    step();
    step();

    // in_valid while busy must be ignored, and in_ready stays low through a held FINAL
    hold_out = 1'b1;
    send({64{1'b1}}, 80'h0);
    repeat (20) step();
    in_block = 64'h0123456789ABCDEF;
    in_key   = 80'h13579BDF02468ACE1357;
    in_valid = 1'b1;
    repeat (5) step();
    in_valid = 1'b0;
    wait_out_valid();
    repeat (3) step();
    check_int("busy_in_ready_final", int'(in_ready), 0);
    hold_out = 1'b0;
    wait_done(6);
    check64("ct_busy_ignore", result_at(5), 64'hA112FFC72F68417B);
    check_int("no_extra_accept", accept_count, 6);

    // reset in the WAIT of round 10, then a spurious return
    send(64'h0, {80{1'b1}});
    t = 0;
    while (!(pending && pend_round == 10) && t < 500) begin
      step();
      t++;
    end
    check_int("reach_round10", int'(pending && pend_round == 10), 1);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    force_ret = 1'b1;
    check_int("abort_in_ready", int'(in_ready), 1);
    check_int("abort_sub_valid", int'(sub_valid), 0);
    check_int("abort_out_valid", int'(out_valid), 0);
    step();
    check_int("spurious_in_ready", int'(in_ready), 1);
    check_int("spurious_sub_valid", int'(sub_valid), 0);
    n = results.size();
    send({64{1'b1}}, {80{1'b1}});
    wait_done(n + 1);
    check64("ct_after_abort", result_at(n), 64'h3333DCD3213210D2);

    // back-to-back blocks
    n = results.size();
    send(64'h0, 80'h0);
    wait_out_valid();
    send(64'h0, {80{1'b1}});
    check_int("b2b_gap", accept_cyc - out_hs_cyc, 1);
    wait_done(n + 2);
    check64("ct_b2b_first", result_at(n), 64'h5579C1387B228445);
    check64("ct_b2b_second", result_at(n + 1), 64'hE72C46C0F5945049);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
